// File: rtl/triple_generator_pipe_if.sv
// ---------------------------------------------------------------------------
// triple_generator_pipe_if
//
// Purpose:
//   Bundles the operand-side and result-side valid/ready handshakes of the
//   triple generator pipeline into one interface.
//
// Signals:
//   in_valid     operand pair valid                  (source -> generator)
//   in_ready     generator can accept this cycle     (generator -> source)
//   a, b         unsigned operands, WIDTH bits        (source -> generator)
//   out_valid    result triple valid                  (generator -> consumer)
//   out_ready    consumer accepts result this cycle   (consumer -> generator)
//   aa_minus_bb  scaled a*a minus scaled b*b          (generator -> consumer)
//   two_ab       scaled a*b doubled                   (generator -> consumer)
//   aa_plus_bb   scaled a*a plus scaled b*b           (generator -> consumer)
//   ovf          result out of range flag             (generator -> consumer)
//
// Modports:
//   master  the environment driving operands and consuming results
//   slave   the generator itself
// ---------------------------------------------------------------------------
interface triple_generator_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] aa_minus_bb;
    logic [WIDTH-1:0] two_ab;
    logic [WIDTH-1:0] aa_plus_bb;
    logic             ovf;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  aa_minus_bb,
        input  two_ab,
        input  aa_plus_bb,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output aa_minus_bb,
        output two_ab,
        output aa_plus_bb,
        output ovf
    );
endinterface

// File: rtl/triple_generator_pipe.sv
// ---------------------------------------------------------------------------
// triple_generator_pipe
//
// Purpose:
//   Three-stage pipelined generator of Pythagorean-style triples. From the
//   unsigned operands (a, b) it produces
//       aa_minus_bb = (a*a >> FRAC) - (b*b >> FRAC)
//       two_ab      = (a*b >> FRAC) << 1
//       aa_plus_bb  = (a*a >> FRAC) + (b*b >> FRAC)
//   at one result per cycle with valid/ready flow control on both sides.
//
//   Stage 1 registers the operands, stage 2 registers the scaled products,
//   stage 3 registers the finished triple. A single advance enable
//   (en = ~out_valid | out_ready) moves every stage together, so a stalled
//   output freezes the whole pipe and in_ready follows en combinationally.
//
// Parameters:
//   WIDTH  operand and result width, at least 4
//   FRAC   number of fraction bits removed from every product (0..WIDTH-1)
//
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  asynchronous active-high reset
//   bus  triple_generator_pipe_if.slave (operand and result handshakes)
//
// Build option:
//   TRIPLE_SATURATE_EN  when defined, each result is clamped (negative
//                       difference -> 0, over-range -> all ones) and ovf
//                       flags any clamp or product overflow. When undefined,
//                       results wrap modulo 2^WIDTH and ovf is held at 0.
//                       Latency and handshake are the same in both builds.
// ---------------------------------------------------------------------------
module triple_generator_pipe #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    triple_generator_pipe_if.slave  bus
);

    localparam int PW = 2 * WIDTH;

    // Stage 2 storage width. The saturating build needs the full scaled
    // products to judge range; the wrapping build only ever uses the low
    // bits, and for a*b only the bits that survive the doubling shift.
`ifdef TRIPLE_SATURATE_EN
    localparam int SQ_W = PW;
    localparam int AB_W = PW;
`else
    localparam int SQ_W = WIDTH;
    localparam int AB_W = WIDTH - 1;
`endif

    // ---------------------------------------------------------------
    // Flow control
    // ---------------------------------------------------------------
    logic en;
    logic out_valid_q;

    assign en           = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_q;

    // ---------------------------------------------------------------
    // Stage 1: operand capture
    // ---------------------------------------------------------------
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Operand data only loads on a real transfer so bubbles leave the
    // previous operands in place; the valid bit alone marks a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a <= bus.a;
                s1_b <= bus.b;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: full-width products, fixed-point scaling
    // ---------------------------------------------------------------
    logic [PW-1:0]   prod_aa;
    logic [PW-1:0]   prod_bb;
    logic [PW-1:0]   prod_ab;
    logic [SQ_W-1:0] scaled_aa;
    logic [SQ_W-1:0] scaled_bb;
    logic [AB_W-1:0] scaled_ab;

    // Operands are zero-extended first so the multiply is done at the
    // full 2*WIDTH precision before the fraction bits are dropped.
    assign prod_aa = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_a};
    assign prod_bb = {{WIDTH{1'b0}}, s1_b} * {{WIDTH{1'b0}}, s1_b};
    assign prod_ab = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};

    assign scaled_aa = SQ_W'(prod_aa >> FRAC);
    assign scaled_bb = SQ_W'(prod_bb >> FRAC);
    assign scaled_ab = AB_W'(prod_ab >> FRAC);

    logic            s2_valid;
    logic [SQ_W-1:0] s2_aa;
    logic [SQ_W-1:0] s2_bb;
    logic [AB_W-1:0] s2_ab;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_aa    <= '0;
            s2_bb    <= '0;
            s2_ab    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_aa <= scaled_aa;
                s2_bb <= scaled_bb;
                s2_ab <= scaled_ab;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 3: result arithmetic
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] res_diff;
    logic [WIDTH-1:0] res_two;
    logic [WIDTH-1:0] res_sum;

`ifdef TRIPLE_SATURATE_EN
    logic [PW:0] diff_full;
    logic [PW:0] sum_full;
    logic        diff_neg;
    logic        diff_hi;
    logic        sum_hi;
    logic        aa_hi;
    logic        bb_hi;
    logic        ab_hi;
    logic        res_ovf;

    // Range decisions use the untruncated scaled products, so a product
    // that overflowed WIDTH still clamps to the correct end of the range.
    // ab_hi covers both an oversize product and the top bit that the
    // doubling would shift out.
    always_comb begin
        diff_full = {1'b0, s2_aa} - {1'b0, s2_bb};
        sum_full  = {1'b0, s2_aa} + {1'b0, s2_bb};
        diff_neg  = diff_full[PW];
        diff_hi   = |diff_full[PW-1:WIDTH];
        sum_hi    = |sum_full[PW:WIDTH];
        aa_hi     = |s2_aa[PW-1:WIDTH];
        bb_hi     = |s2_bb[PW-1:WIDTH];
        ab_hi     = |s2_ab[PW-1:WIDTH-1];

        if (diff_neg) begin
            res_diff = '0;
        end else if (diff_hi) begin
            res_diff = '1;
        end else begin
            res_diff = diff_full[WIDTH-1:0];
        end

        if (ab_hi) begin
            res_two = '1;
        end else begin
            res_two = {s2_ab[WIDTH-2:0], 1'b0};
        end

        if (sum_hi) begin
            res_sum = '1;
        end else begin
            res_sum = sum_full[WIDTH-1:0];
        end

        res_ovf = diff_neg | diff_hi | sum_hi | aa_hi | bb_hi | ab_hi;
    end
`else
    // Plain modulo-2^WIDTH arithmetic on the truncated products.
    always_comb begin
        res_diff = s2_aa - s2_bb;
        res_two  = {s2_ab, 1'b0};
        res_sum  = s2_aa + s2_bb;
    end
`endif

    // ---------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] aa_minus_bb_q;
    logic [WIDTH-1:0] two_ab_q;
    logic [WIDTH-1:0] aa_plus_bb_q;

    // Held whenever en is low, which keeps a presented result stable until
    // the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            aa_minus_bb_q <= '0;
            two_ab_q      <= '0;
            aa_plus_bb_q  <= '0;
        end else if (en) begin
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                aa_minus_bb_q <= res_diff;
                two_ab_q      <= res_two;
                aa_plus_bb_q  <= res_sum;
            end
        end
    end

    assign bus.aa_minus_bb = aa_minus_bb_q;
    assign bus.two_ab      = two_ab_q;
    assign bus.aa_plus_bb  = aa_plus_bb_q;

`ifdef TRIPLE_SATURATE_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (en && s2_valid) begin
            ovf_q <= res_ovf;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_triple_generator_pipe.sv
// ---------------------------------------------------------------------------
// tb_triple_generator_pipe
//
// Purpose:
//   Self-checking bench for triple_generator_pipe. One instance runs with
//   FRAC=0, a second with FRAC=16. Expected triples come from an arithmetic
//   model and flow through a scoreboard queue; per-scenario tasks also check
//   reset values, latency, stall behaviour and reset during operation.
//   Expected values follow TRIPLE_SATURATE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_triple_generator_pipe;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] d;
        logic [W-1:0] t;
        logic [W-1:0] s;
        logic         o;
    } res_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    res_t         exp_q[$];
    logic [W-1:0] stim_a[$];
    logic [W-1:0] stim_b[$];

    triple_generator_pipe_if #(.WIDTH(W)) bus0 ();
    triple_generator_pipe_if #(.WIDTH(W)) bus16 ();

    triple_generator_pipe #(.WIDTH(W), .FRAC(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    triple_generator_pipe #(.WIDTH(W), .FRAC(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic model of one triple.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int frac);
        logic [63:0] aa;
        logic [63:0] bb;
        logic [63:0] ab;
        res_t        r;
`ifdef TRIPLE_SATURATE_EN
        logic [64:0] sum;
        logic [63:0] diff;
`endif
        aa = ({32'd0, a} * {32'd0, a}) >> frac;
        bb = ({32'd0, b} * {32'd0, b}) >> frac;
        ab = ({32'd0, a} * {32'd0, b}) >> frac;
`ifdef TRIPLE_SATURATE_EN
        r.o = 1'b0;
        if (bb > aa) begin
            r.d = '0;
            r.o = 1'b1;
        end else begin
            diff = aa - bb;
            if (diff[63:32] != 32'd0) begin
                r.d = '1;
                r.o = 1'b1;
            end else begin
                r.d = diff[31:0];
            end
        end
        if (ab[63:31] != 33'd0) begin
            r.t = '1;
            r.o = 1'b1;
        end else begin
            r.t = {ab[30:0], 1'b0};
        end
        sum = {1'b0, aa} + {1'b0, bb};
        if (sum[64:32] != 33'd0) begin
            r.s = '1;
            r.o = 1'b1;
        end else begin
            r.s = sum[31:0];
        end
        if (aa[63:32] != 32'd0 || bb[63:32] != 32'd0) r.o = 1'b1;
`else
        r.d = aa[31:0] - bb[31:0];
        r.t = {ab[30:0], 1'b0};
        r.s = aa[31:0] + bb[31:0];
        r.o = 1'b0;
`endif
        return r;
    endfunction

    task automatic test_reset;
        rst             = 1'b1;
        bus0.in_valid   = 1'b0;
        bus0.a          = '0;
        bus0.b          = '0;
        bus0.out_ready  = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid got=%b exp=0", bus0.out_valid);
        end
        checks++;
        if ({bus0.aa_minus_bb, bus0.two_ab, bus0.aa_plus_bb} !== {3*W{1'b0}}) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h/%h/%h exp=0/0/0",
                     bus0.aa_minus_bb, bus0.two_ab, bus0.aa_plus_bb);
        end
        checks++;
        if (bus0.ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ovf got=%b exp=0", bus0.ovf);
        end
        checks++;
        if (bus0.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", bus0.in_ready);
        end
        checks++;
        if (bus16.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid16 got=%b exp=0", bus16.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // a=2,b=1: result visible after the third rising edge counting the
    // edge that accepts the operands.
    task automatic test_latency;
        @(negedge clk);
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.a         = 32'd2;
        bus0.b         = 32'd1;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_edge1 got=%b exp=0", bus0.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_edge2 got=%b exp=0", bus0.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus0.out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_edge3 got=%b exp=1", bus0.out_valid);
        end
        checks++;
        if ({bus0.aa_minus_bb, bus0.two_ab, bus0.aa_plus_bb, bus0.ovf} !==
            {32'd3, 32'd4, 32'd5, 1'b0}) begin
            failures++;
            $display("[TB] FAIL latency_value got=%h/%h/%h ovf=%b exp=3/4/5 ovf=0",
                     bus0.aa_minus_bb, bus0.two_ab, bus0.aa_plus_bb, bus0.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    // Streams stim_a/stim_b into dut0 through the scoreboard.
    // mode 0: out_ready always high; 1: out_ready low for 4 cycles once the
    // first result appears; 2: random out_ready.
    task automatic run_stream(input int mode, input int budget, input string tag);
        int   idx        = 0;
        int   produced   = 0;
        int   total      = stim_a.size();
        int   stall_left = 0;
        int   cyc        = 0;
        bit   first_seen = 1'b0;
        bit   held       = 1'b0;
        res_t held_val   = '0;
        res_t e;
        res_t got;
        while (produced < total && cyc < budget) begin
            @(negedge clk);
            cyc++;
            got = {bus0.aa_minus_bb, bus0.two_ab, bus0.aa_plus_bb, bus0.ovf};
            if (held) begin
                checks++;
                if (bus0.out_valid !== 1'b1 || got !== held_val) begin
                    failures++;
                    $display("[TB] FAIL %s_hold got=%b:%h exp=1:%h", tag, bus0.out_valid, got, held_val);
                end
            end
            if (mode == 1 && !first_seen && bus0.out_valid === 1'b1) begin
                first_seen = 1'b1;
                stall_left = 4;
            end
            if (mode == 2) bus0.out_ready = 1'($urandom_range(0, 1));
            else           bus0.out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (idx < total) begin
                bus0.in_valid = 1'b1;
                bus0.a        = stim_a[idx];
                bus0.b        = stim_b[idx];
            end else begin
                bus0.in_valid = 1'b0;
            end
            #1;
            held = bus0.out_valid && !bus0.out_ready;
            if (held) begin
                held_val = got;
                checks++;
                if (bus0.in_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL %s_in_ready_stall got=%b exp=0", tag, bus0.in_ready);
                end
            end
            if (bus0.out_valid && bus0.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL %s_extra got=%h exp=none", tag, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("[TB] FAIL %s_result#%0d got=%h/%h/%h ovf=%b exp=%h/%h/%h ovf=%b",
                                 tag, produced, got.d, got.t, got.s, got.o, e.d, e.t, e.s, e.o);
                    end
                end
                produced++;
            end
            if (bus0.in_valid && bus0.in_ready) begin
                exp_q.push_back(model(bus0.a, bus0.b, 0));
                idx++;
            end
        end
        @(negedge clk);
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        checks++;
        if (produced != total) begin
            failures++;
            $display("[TB] FAIL %s_count got=%0d exp=%0d", tag, produced, total);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_leftover got=%0d exp=0", tag, exp_q.size());
        end
        exp_q.delete();
        stim_a.delete();
        stim_b.delete();
    endtask

    task automatic test_patterns;
        stim_a = '{32'd1, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_7FFF, 32'h0000_B505, 32'd0, 32'd100};
        stim_b = '{32'd2, 32'd0,         32'hFFFF_FFFF, 32'h0000_7FFF, 32'h0000_0001, 32'd9, 32'd0};
        run_stream(0, 100, "patterns");
        for (int i = 0; i < 20; i++) begin
            stim_a.push_back($urandom);
            stim_b.push_back(32'($urandom_range(0, 32'h0001_FFFF)));
        end
        run_stream(2, 400, "random");
    endtask

    task automatic test_frac;
        logic [W-1:0] fa[4] = '{32'h0002_0000, 32'h0001_8000, 32'h0000_0100, 32'h0003_0000};
        logic [W-1:0] fb[4] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0080, 32'h0004_0000};
        res_t q16[$];
        res_t e;
        res_t got;
        int   idx      = 0;
        int   produced = 0;
        int   cyc      = 0;
        bus16.out_ready = 1'b1;
        while (produced < 4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (idx < 4) begin
                bus16.in_valid = 1'b1;
                bus16.a        = fa[idx];
                bus16.b        = fb[idx];
            end else begin
                bus16.in_valid = 1'b0;
            end
            #1;
            if (bus16.out_valid) begin
                got = {bus16.aa_minus_bb, bus16.two_ab, bus16.aa_plus_bb, bus16.ovf};
                checks++;
                if (q16.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL frac_extra got=%h exp=none", got);
                end else begin
                    e = q16.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("[TB] FAIL frac_result#%0d got=%h/%h/%h ovf=%b exp=%h/%h/%h ovf=%b",
                                 produced, got.d, got.t, got.s, got.o, e.d, e.t, e.s, e.o);
                    end
                end
                if (produced == 0) begin
                    checks++;
                    if ({got.d, got.t, got.s} !== {32'h0003_0000, 32'h0004_0000, 32'h0005_0000}) begin
                        failures++;
                        $display("[TB] FAIL frac_first got=%h/%h/%h exp=00030000/00040000/00050000",
                                 got.d, got.t, got.s);
                    end
                end
                produced++;
            end
            if (bus16.in_valid && bus16.in_ready) begin
                q16.push_back(model(bus16.a, bus16.b, 16));
                idx++;
            end
        end
        @(negedge clk);
        bus16.in_valid = 1'b0;
        checks++;
        if (produced != 4) begin
            failures++;
            $display("[TB] FAIL frac_count got=%0d exp=4", produced);
        end
    endtask

    task automatic test_back_to_back;
        stim_a = '{32'd3, 32'd5,  32'd8,  32'd20, 32'd9};
        stim_b = '{32'd4, 32'd12, 32'd15, 32'd21, 32'd40};
        run_stream(1, 100, "b2b");
    endtask

    task automatic test_reset_midflight;
        int stale = 0;
        logic [W-1:0] ra[3] = '{32'd7, 32'd9, 32'd11};
        logic [W-1:0] rb[3] = '{32'd2, 32'd4, 32'd6};
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus0.in_valid = 1'b1;
            bus0.a        = ra[i];
            bus0.b        = rb[i];
        end
        @(negedge clk);
        bus0.in_valid = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_pre got=%b exp=1", bus0.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_out_valid got=%b exp=0", bus0.out_valid);
        end
        checks++;
        if ({bus0.aa_minus_bb, bus0.two_ab, bus0.aa_plus_bb, bus0.ovf} !== {3*W+1{1'b0}}) begin
            failures++;
            $display("[TB] FAIL midreset_data got=%h/%h/%h ovf=%b exp=0/0/0 ovf=0",
                     bus0.aa_minus_bb, bus0.two_ab, bus0.aa_plus_bb, bus0.ovf);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus0.out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("[TB] FAIL midreset_stale got=%0d exp=0", stale);
        end
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.a        = 32'd5;
        bus0.b        = 32'd2;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_early got=%b exp=0", bus0.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus0.out_valid !== 1'b1 ||
            {bus0.aa_minus_bb, bus0.two_ab, bus0.aa_plus_bb, bus0.ovf} !== {32'd21, 32'd20, 32'd29, 1'b0}) begin
            failures++;
            $display("[TB] FAIL midreset_after got=%b:%h/%h/%h ovf=%b exp=1:15/14/1d ovf=0",
                     bus0.out_valid, bus0.aa_minus_bb, bus0.two_ab, bus0.aa_plus_bb, bus0.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_frac();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a scenario wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
